// File: rtl/reg_file_dump_pkg.sv
// Shared types and sizing for the register-file debug dumper.
package reg_file_dump_pkg;

  localparam int NUM_REGS       = 32;
  localparam int REG_ADDR_WIDTH = $clog2(NUM_REGS);
  localparam int DUMP_DATA_W    = 32;  // XLEN of the RV32I core

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_t;

endpackage

// File: rtl/reg_file_dumper.sv
// Walks every register through one reg_file read port and streams
// {idx, data, last} words out over a valid/ready handshake.
module reg_file_dumper #(
  parameter int NUM_REGS   = reg_file_dump_pkg::NUM_REGS,
  parameter int ADDR_WIDTH = reg_file_dump_pkg::REG_ADDR_WIDTH,
  parameter int DATA_WIDTH = reg_file_dump_pkg::DUMP_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] rd_reg,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_idx,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);
  import reg_file_dump_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  dump_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0] out_idx_q, out_idx_d;
  logic                  out_last_q, out_last_d;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = READ;
          idx_d   = '0;
        end
      end
      READ: begin
        out_data_d  = rd_data;
        out_idx_d   = idx_q;
        out_last_d  = (idx_q == LAST_IDX);
        out_valid_d = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          // Terminal test uses the captured last flag, so idx never wraps.
          if (out_last_q) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + ADDR_WIDTH'(1);
            state_d = READ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over a same-cycle handshake and suppresses the done pulse.
    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      idx_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
    end
  end

  assign rd_reg    = (state_q == READ) ? idx_q : '0;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule
